// File: rtl/char_pkg.sv
// Shared types and character constants for the character buffer slice.
package char_pkg;

   typedef enum logic [1:0] {CLEAR, IDLE, ACK, EXEC} state_t;

   localparam logic [7:0] SPACE = 8'h20;
   localparam logic [7:0] BKSP  = 8'h08;
   localparam logic [7:0] FF    = 8'h0C;

endpackage

// File: rtl/char_buf_if.sv
// Decoder-to-buffer character handshake: read_ready/char_in offered, read acknowledges.
interface char_buf_if #(
   parameter int CHAR_W = 8
) ();

   logic              read_ready;
   logic [CHAR_W-1:0] char_in;
   logic              read;

   modport master (output read_ready, output char_in, input read);
   modport slave  (input read_ready, input char_in, output read);

endinterface

// File: rtl/char_ram.sv
// Character store: one synchronous write port, one registered read port (read-before-write), no reset.
module char_ram #(
   parameter int CHAR_W = 8,
   parameter int DEPTH  = 32,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [CHAR_W-1:0] wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [CHAR_W-1:0] rdata
);

   logic [CHAR_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      rdata <= mem[raddr];
   end

endmodule

// File: rtl/char_buf.sv
// Character buffer between the scan-code decoder and the text renderer, with
// backspace/clear interpretation and STOP or SCROLL handling when full.
module char_buf
   import char_pkg::*;
#(
   parameter int                CHAR_W    = 8,
   parameter int                DEPTH     = 32,
   parameter int                ADDR_W    = $clog2(DEPTH),
   parameter bit                SCROLL    = 1'b0,
   parameter logic [CHAR_W-1:0] FILL_CHAR = CHAR_W'(SPACE),
   parameter logic [CHAR_W-1:0] BKSP_CODE = CHAR_W'(BKSP),
   parameter logic [CHAR_W-1:0] CLR_CODE  = CHAR_W'(FF)
) (
   input  logic              clk,
   input  logic              rst,
   char_buf_if.slave         dec,
   input  logic              clear,
   input  logic [ADDR_W-1:0] char_addr,
   output logic [CHAR_W-1:0] char_out,
   output logic [ADDR_W:0]   count,
   output logic              full,
   output logic              busy,
   output logic              overflow
);

   state_t            state;
   logic [ADDR_W-1:0] idx;
   logic [ADDR_W-1:0] base;
   logic [CHAR_W-1:0] hold;
   logic              read_q;
   logic              fill_sel;

   logic              we;
   logic [ADDR_W-1:0] waddr;
   logic [CHAR_W-1:0] wdata;
   logic [CHAR_W-1:0] rd_data;
   logic [ADDR_W-1:0] wr_ptr;
   logic [ADDR_W-1:0] bk_ptr;

   assign full     = (count == (ADDR_W+1)'(DEPTH));
   assign dec.read = read_q;
   // When full, the low count bits wrap to 0 so wr_ptr lands on base: the scroll target.
   assign wr_ptr   = base + count[ADDR_W-1:0];
   assign bk_ptr   = wr_ptr - ADDR_W'(1);
   // fill_sel lags busy by one edge so char_out stays registered relative to busy.
   assign char_out = fill_sel ? FILL_CHAR : rd_data;

   always_comb begin
      we    = 1'b0;
      waddr = idx;
      wdata = FILL_CHAR;
      unique case (state)
         CLEAR: we = 1'b1;
         EXEC: begin
            if (hold == BKSP_CODE) begin
               if (count != '0) begin
                  we    = 1'b1;
                  waddr = bk_ptr;
               end
            end else if (hold != CLR_CODE) begin
               if (!full || SCROLL) begin
                  we    = 1'b1;
                  waddr = wr_ptr;
                  wdata = hold;
               end
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= CLEAR;
         idx      <= '0;
         base     <= '0;
         count    <= '0;
         read_q   <= 1'b0;
         overflow <= 1'b0;
         busy     <= 1'b1;
         hold     <= '0;
         fill_sel <= 1'b1;
      end else begin
         read_q   <= 1'b0;
         overflow <= 1'b0;
         fill_sel <= busy;
         unique case (state)
            CLEAR: begin
               idx <= idx + ADDR_W'(1);
               if (idx == ADDR_W'(DEPTH-1)) begin
                  state <= IDLE;
                  busy  <= 1'b0;
                  base  <= '0;
                  count <= '0;
               end
            end
            IDLE: begin
               if (clear) begin
                  state <= CLEAR;
                  busy  <= 1'b1;
                  idx   <= '0;
               end else if (dec.read_ready) begin
                  state  <= ACK;
                  read_q <= 1'b1;
               end
            end
            ACK: begin
               hold  <= dec.char_in;
               state <= EXEC;
            end
            EXEC: begin
               state <= IDLE;
               if (hold == CLR_CODE) begin
                  state <= CLEAR;
                  busy  <= 1'b1;
                  idx   <= '0;
               end else if (hold == BKSP_CODE) begin
                  if (count != '0) count <= count - (ADDR_W+1)'(1);
               end else if (!full) begin
                  count <= count + (ADDR_W+1)'(1);
               end else if (SCROLL) begin
                  base <= base + ADDR_W'(1);
               end else begin
                  overflow <= 1'b1;
               end
            end
            default: state <= CLEAR;
         endcase
      end
   end

   char_ram #(
      .CHAR_W (CHAR_W),
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_ram (
      .clk   (clk),
      .we    (we),
      .waddr (waddr),
      .wdata (wdata),
      .raddr (base + char_addr),
      .rdata (rd_data)
   );

endmodule

// File: tb/tb_char_buf.sv
// Directed bench for char_buf: a STOP-mode and a SCROLL-mode instance checked against a queue model.
module tb_char_buf;
   import char_pkg::*;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rr  = 1'b0;
   logic       clr = 1'b0;
   logic       sel = 1'b0;
   logic [7:0] ch  = 8'h00;
   logic [4:0] addr = 5'd0;

   always #5 clk = ~clk;

   char_buf_if #(.CHAR_W(8)) if0 ();
   char_buf_if #(.CHAR_W(8)) if1 ();

   assign if0.read_ready = rr & ~sel;
   assign if1.read_ready = rr & sel;
   assign if0.char_in    = ch;
   assign if1.char_in    = ch;

   logic [7:0] co0, co1;
   logic [5:0] cn0, cn1;
   logic       fu0, fu1, bu0, bu1, ov0, ov1;

   char_buf #(.SCROLL(1'b0)) u0 (
      .clk(clk), .rst(rst), .dec(if0), .clear(clr & ~sel), .char_addr(addr),
      .char_out(co0), .count(cn0), .full(fu0), .busy(bu0), .overflow(ov0)
   );

   char_buf #(.SCROLL(1'b1)) u1 (
      .clk(clk), .rst(rst), .dec(if1), .clear(clr & sel), .char_addr(addr),
      .char_out(co1), .count(cn1), .full(fu1), .busy(bu1), .overflow(ov1)
   );

   logic       o_read, o_full, o_busy, o_ov;
   logic [7:0] o_char;
   logic [5:0] o_count;
   assign o_read  = sel ? if1.read : if0.read;
   assign o_char  = sel ? co1 : co0;
   assign o_count = sel ? cn1 : cn0;
   assign o_full  = sel ? fu1 : fu0;
   assign o_busy  = sel ? bu1 : bu0;
   assign o_ov    = sel ? ov1 : ov0;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int last_rd = -100;
   logic [7:0] mq [$];
   logic [7:0] exp_q [$];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Offer one character; the model predicts the buffer contents and overflow.
   task automatic send(input logic [7:0] c, input bit keep);
      bit   seen;
      logic exp_ov;
      seen   = 1'b0;
      exp_ov = 1'b0;
      ch = c;
      rr = 1'b1;
      for (int i = 0; i < 12 && !seen; i++) begin
         tick();
         if (o_read === 1'b1) seen = 1'b1;
      end
      chk("read_seen", 32'(seen), 32'd1);
      if (!seen) begin
         rr = keep;
         return;
      end
      chk("read_gap", 32'((cyc - last_rd) >= 3), 32'd1);
      last_rd = cyc;
      if (c == FF) mq.delete();
      else if (c == BKSP) begin
         if (mq.size() > 0) void'(mq.pop_back());
      end else if (mq.size() < 32) mq.push_back(c);
      else if (sel) begin
         void'(mq.pop_front());
         mq.push_back(c);
      end else exp_ov = 1'b1;
      tick();
      chk("read_width", 32'(o_read), 32'd0);
      if (!keep) rr = 1'b0;
      tick();
      chk("overflow", 32'(o_ov), 32'(exp_ov));
      if (exp_ov) begin
         tick();
         chk("overflow_pulse", 32'(o_ov), 32'd0);
      end
   endtask

   task automatic sweep_check();
      for (int i = 0; i < 32; i++) begin
         chk("busy_sweep", 32'(o_busy), 32'd1);
         chk("no_read_sweep", 32'(o_read), 32'd0);
         tick();
      end
      chk("busy_done", 32'(o_busy), 32'd0);
      chk("count_after_clear", 32'(o_count), 32'd0);
   endtask

   task automatic check_contents();
      for (int a = 0; a < 32; a++) begin
         exp_q.push_back(a < mq.size() ? mq[a] : SPACE);
         addr = 5'(a);
         tick();
         chk("char_out", 32'(o_char), 32'(exp_q.pop_front()));
      end
      chk("count", 32'(o_count), 32'(mq.size()));
      chk("full", 32'(o_full), 32'(mq.size() == 32));
   endtask

   initial begin
      // 1: reset values, then a full sweep from reset release
      tick();
      tick();
      chk("rst_busy", 32'(o_busy), 32'd1);
      chk("rst_count", 32'(o_count), 32'd0);
      chk("rst_read", 32'(o_read), 32'd0);
      chk("rst_overflow", 32'(o_ov), 32'd0);
      chk("rst_char_out", 32'(o_char), 32'h20);
      rst = 1'b0;
      sweep_check();
      check_contents();

      // 2: two characters
      send(8'h41, 1'b0);
      send(8'h42, 1'b0);
      check_contents();

      // 3: backspace down to and past empty
      send(BKSP, 1'b0);
      check_contents();
      for (int i = 0; i < 3; i++) send(BKSP, 1'b0);
      check_contents();

      // 4: STOP mode fill and overflow
      for (int i = 0; i < 33; i++) begin
         send(8'(8'h41 + i), 1'b0);
         if (i == 31) chk("full_at_32", 32'(o_full), 32'd1);
      end
      check_contents();

      // 5: SCROLL mode on the second instance
      sel = 1'b1;
      mq.delete();
      last_rd = -100;
      for (int i = 0; i < 33; i++) send(8'(8'h41 + i), 1'b0);
      check_contents();

      // 6: clear code with read_ready held, then reset mid-sweep
      sel = 1'b0;
      last_rd = -100;
      send(FF, 1'b0);
      sweep_check();
      for (int i = 0; i < 5; i++) send(8'(8'h61 + i), 1'b0);
      check_contents();
      send(FF, 1'b1);
      sweep_check();
      rr = 1'b0;
      check_contents();
      send(FF, 1'b0);
      for (int i = 0; i < 10; i++) begin
         chk("busy_pre_rst", 32'(o_busy), 32'd1);
         tick();
      end
      rst = 1'b1;
      tick();
      chk("busy_in_rst", 32'(o_busy), 32'd1);
      chk("read_in_rst", 32'(o_read), 32'd0);
      rst = 1'b0;
      sweep_check();
      check_contents();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
